hazard_fwd_unit: RTL and testbench

//  Parametrised D-stage hazard unit for the pipelined MIPS core, generalising the D-stage compare forwarding mux.

---
 rtl/hazard_fwd_unit_pkg.sv | 32 +++
 rtl/hfu_port_sel.sv | 36 +++
 rtl/hazard_fwd_unit.sv | 130 +++++++++++++
 tb/tb_hazard_fwd_unit.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared definitions for the D-stage hazard/forwarding unit: field widths,
// stage index constants and the scoreboard entry layout.
package hazard_fwd_unit_pkg;

   // Register number, Tnew and Tuse field widths
   localparam int unsigned REG_W  = 5;
   localparam int unsigned TNEW_W = 2;
   localparam int unsigned TUSE_W = 2;

   // Stage indices of the default three-deep tracking window after D
   localparam int unsigned STG_E = 0;
   localparam int unsigned STG_M = 1;
   localparam int unsigned STG_W = 2;

   // One in-flight write: {valid, destination register, cycles until ready}
   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  a3;
      logic [TNEW_W-1:0] tnew;
   } sb_entry_t;

   // Tnew counts down as the producer moves one stage older; it never wraps
   function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] t);
      return (t == '0) ? '0 : (t - TNEW_W'(1));
   endfunction

   // A pending write is relevant to a read port only for a real (non-$0) register
   function automatic logic entry_match(input sb_entry_t e, input logic [REG_W-1:0] ra);
      return e.valid && (e.a3 == ra) && (ra != '0);
   endfunction

endpackage

// File: rtl/hfu_port_sel.sv
// Youngest-producer search for a single D-stage read port.
// Returns a one-hot stage select (all zero = use register-file data) and a
// per-port stall request.
module hfu_port_sel
   import hazard_fwd_unit_pkg::*;
#(
   parameter int unsigned NSTAGE = 3
)
(
   input  sb_entry_t [NSTAGE-1:0] sb,
   input  logic [REG_W-1:0]       rd_addr,
   input  logic [TUSE_W-1:0]      tuse,
   output logic [NSTAGE-1:0]      fwd_sel,
   output logic                   stall_r
);

   logic found;

   // Scan from E outward; only the first (youngest) match decides the outcome
   always_comb begin
      fwd_sel = '0;
      stall_r = 1'b0;
      found   = 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
         if (!found && entry_match(sb[k], rd_addr)) begin
            found = 1'b1;
            if (sb[k].tnew == '0) begin
               fwd_sel[k] = 1'b1;
            end else if (sb[k].tnew > tuse) begin
               stall_r = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// D-stage hazard and forwarding unit for the pipelined MIPS core.
// Tracks in-flight GPR writes for NSTAGE stages after D, forwards the
// youngest ready producer to each D read port and stalls on Tuse/Tnew
// conflicts. Stall only inserts a bubble into E; E..W always advance.
// Optional feature: define MDU_EN to track the mult/div busy window.
module hazard_fwd_unit
   import hazard_fwd_unit_pkg::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned NSTAGE  = 3,
   parameter int unsigned NREAD   = 2,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [REG_W*NREAD-1:0]   rd_addr,
   input  logic [TUSE_W*NREAD-1:0]  tuse,
   input  logic [DW*NREAD-1:0]      rf_rd,
   input  logic                     wr_en_d,
   input  logic [REG_W-1:0]         a3_d,
   input  logic [TNEW_W-1:0]        tnew_d,
   input  logic [DW*NSTAGE-1:0]     stage_res,
   input  logic                     md_start,
   input  logic                     md_div,
   input  logic                     md_use_d,
   output logic [DW*NREAD-1:0]      fwd_data,
   output logic                     stall,
   output logic                     md_busy
);

   sb_entry_t [NSTAGE-1:0] sb_q;
   sb_entry_t [NSTAGE-1:0] sb_d;
   logic [NSTAGE-1:0]      fwd_sel [NREAD];
   logic [NREAD-1:0]       port_stall;
   logic                   md_stall;

   // One youngest-match search per read port
   for (genvar r = 0; r < NREAD; r++) begin : g_port
      hfu_port_sel #(
         .NSTAGE (NSTAGE)
      ) u_port_sel (
         .sb      (sb_q),
         .rd_addr (rd_addr[r*REG_W +: REG_W]),
         .tuse    (tuse[r*TUSE_W +: TUSE_W]),
         .fwd_sel (fwd_sel[r]),
         .stall_r (port_stall[r])
      );
   end

   // Operand mux: register-file data unless a ready producer was selected
   always_comb begin
      fwd_data = rf_rd;
      for (int r = 0; r < NREAD; r++) begin
         for (int k = 0; k < NSTAGE; k++) begin
            if (fwd_sel[r][k]) begin
               fwd_data[r*DW +: DW] = stage_res[k*DW +: DW];
            end
         end
      end
   end

   // Any port conflict or a HI/LO access during a mult/div freezes D
   always_comb begin
      stall = (|port_stall) | md_stall;
   end

   // Scoreboard shift: D enters E (or a bubble on stall), older entries age
   always_comb begin
      sb_d = sb_q;
      if (stall) begin
         sb_d[STG_E] = '0;
      end else begin
         sb_d[STG_E].valid = wr_en_d && (a3_d != '0);
         sb_d[STG_E].a3    = a3_d;
         sb_d[STG_E].tnew  = tnew_d;
      end
      for (int k = 1; k < NSTAGE; k++) begin
         sb_d[k]      = sb_q[k-1];
         sb_d[k].tnew = sat_dec(sb_q[k-1].tnew);
      end
   end

   // Scoreboard register; reset empties every stage
   always_ff @(posedge clk) begin
      if (reset) begin
         sb_q <= '0;
      end else begin
         sb_q <= sb_d;
      end
   end

`ifdef MDU_EN
   localparam int unsigned MD_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int unsigned CNT_W  = $clog2(MD_MAX + 1);

   logic [CNT_W-1:0] md_cnt_q;
   logic [CNT_W-1:0] md_cnt_d;

   assign md_busy  = (md_cnt_q != '0);
   assign md_stall = md_use_d && md_busy;

   // Busy counter: loads on an issuing mult/div, counts down to idle
   always_comb begin
      md_cnt_d = md_cnt_q;
      if (md_start && !stall) begin
         md_cnt_d = md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (md_busy) begin
         md_cnt_d = md_cnt_q - CNT_W'(1);
      end
   end

   // Busy counter register
   always_ff @(posedge clk) begin
      if (reset) begin
         md_cnt_q <= '0;
      end else begin
         md_cnt_q <= md_cnt_d;
      end
   end
`else
   // Without the multiply/divide unit the md_* inputs have no effect
   logic md_unused;
   assign md_unused = ^{md_start, md_div, md_use_d, MUL_LAT[0], DIV_LAT[0]};
   assign md_busy   = 1'b0;
   assign md_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed testbench for hazard_fwd_unit (default parameters).
module tb_hazard_fwd_unit;
   import hazard_fwd_unit_pkg::*;

   localparam int DW      = 32;
   localparam int NSTAGE  = 3;
   localparam int NREAD   = 2;
   localparam int MUL_LAT = 5;
   localparam int DIV_LAT = 10;

   localparam logic [DW-1:0] RF0 = 32'h1111_1111;
   localparam logic [DW-1:0] RF1 = 32'h2222_2222;

   logic                    clk;
   logic                    reset;
   logic [5*NREAD-1:0]      rd_addr;
   logic [2*NREAD-1:0]      tuse;
   logic [DW*NREAD-1:0]     rf_rd;
   logic                    wr_en_d;
   logic [4:0]              a3_d;
   logic [1:0]              tnew_d;
   logic [DW*NSTAGE-1:0]    stage_res;
   logic                    md_start;
   logic                    md_div;
   logic                    md_use_d;
   logic [DW*NREAD-1:0]     fwd_data;
   logic                    stall;
   logic                    md_busy;

   logic [DW-1:0] fwd0;
   logic [DW-1:0] fwd1;
   assign fwd0 = fwd_data[0  +: DW];
   assign fwd1 = fwd_data[DW +: DW];

   int pass_cnt  = 0;
   int total_cnt = 0;
   logic [DW-1:0] exp_q[$];

   hazard_fwd_unit #(
      .DW (DW), .NSTAGE (NSTAGE), .NREAD (NREAD), .MUL_LAT (MUL_LAT), .DIV_LAT (DIV_LAT)
   ) dut (
      .clk (clk), .reset (reset), .rd_addr (rd_addr), .tuse (tuse), .rf_rd (rf_rd),
      .wr_en_d (wr_en_d), .a3_d (a3_d), .tnew_d (tnew_d), .stage_res (stage_res),
      .md_start (md_start), .md_div (md_div), .md_use_d (md_use_d),
      .fwd_data (fwd_data), .stall (stall), .md_busy (md_busy)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Distinct per-stage result value so the chosen stage is visible
   function automatic logic [DW-1:0] sr(input int k);
      return 32'h5000_0000 | DW'(k);
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_rd(input int port, input logic [4:0] a, input logic [1:0] t);
      rd_addr[port*5 +: 5] = a;
      tuse[port*2 +: 2]    = t;
   endtask

   task automatic set_wr(input logic en, input logic [4:0] a, input logic [1:0] t);
      wr_en_d = en;
      a3_d    = a;
      tnew_d  = t;
   endtask

   task automatic idle_inputs();
      rd_addr  = '0;
      tuse     = '0;
      set_wr(1'b0, 5'd0, 2'd0);
      md_start = 1'b0;
      md_div   = 1'b0;
      md_use_d = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      do_reset();
      set_rd(0, 5'd5, 2'd0);
      set_rd(1, 5'd5, 2'd0);
      settle();
      total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (md_busy !== 1'b0) $display("FAIL reset_md_busy: got %b want 0", md_busy); else pass_cnt++;
      total_cnt++; if (fwd0 !== RF0) $display("FAIL reset_fwd0: got %h want %h", fwd0, RF0); else pass_cnt++;
      total_cnt++; if (fwd1 !== RF1) $display("FAIL reset_fwd1: got %h want %h", fwd1, RF1); else pass_cnt++;
   endtask

   // addu $5 (Tnew 1) followed by beq on $5 (Tuse 0)
   task automatic test_alu_branch();
      do_reset();
      set_wr(1'b1, 5'd5, 2'd1);
      step();
      set_wr(1'b0, 5'd0, 2'd0);
      set_rd(0, 5'd5, 2'd0);
      set_rd(1, 5'd5, 2'd2);
      settle();
      total_cnt++; if (stall !== 1'b1) $display("FAIL alu_br_stall: got %b want 1", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== RF0) $display("FAIL alu_br_fwd0_e: got %h want %h", fwd0, RF0); else pass_cnt++;
      total_cnt++; if (fwd1 !== RF1) $display("FAIL alu_br_fwd1_e: got %h want %h", fwd1, RF1); else pass_cnt++;
      step();
      settle();
      total_cnt++; if (stall !== 1'b0) $display("FAIL alu_br_release: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== sr(STG_M)) $display("FAIL alu_br_fwd0_m: got %h want %h", fwd0, sr(STG_M)); else pass_cnt++;
      total_cnt++; if (fwd1 !== sr(STG_M)) $display("FAIL alu_br_fwd1_m: got %h want %h", fwd1, sr(STG_M)); else pass_cnt++;
   endtask

   // lw $6 (Tnew 2) followed by addu $7,$6,$7 (Tuse 1 on $6)
   task automatic test_load_use();
      do_reset();
      set_wr(1'b1, 5'd6, 2'd2);
      step();
      set_wr(1'b1, 5'd7, 2'd1);
      set_rd(0, 5'd6, 2'd1);
      set_rd(1, 5'd7, 2'd0);
      settle();
      total_cnt++; if (stall !== 1'b1) $display("FAIL load_use_stall: got %b want 1", stall); else pass_cnt++;
      step();
      settle();
      // lw now in M with Tnew 1 == Tuse: no stall, operand taken later downstream
      total_cnt++; if (stall !== 1'b0) $display("FAIL load_use_release: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== RF0) $display("FAIL load_use_fwd0_m: got %h want %h", fwd0, RF0); else pass_cnt++;
      total_cnt++; if (fwd1 !== RF1) $display("FAIL load_use_bubble: got %h want %h", fwd1, RF1); else pass_cnt++;
      step();
      set_wr(1'b0, 5'd0, 2'd0);
      set_rd(0, 5'd6, 2'd0);
      set_rd(1, 5'd7, 2'd1);
      settle();
      total_cnt++; if (stall !== 1'b0) $display("FAIL load_use_next_stall: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== sr(STG_W)) $display("FAIL load_use_fwd0_w: got %h want %h", fwd0, sr(STG_W)); else pass_cnt++;
   endtask

   // jal writes $31 with Tnew 0; next beq on $31 forwards from E
   task automatic test_jal();
      do_reset();
      set_wr(1'b1, 5'd31, 2'd0);
      step();
      set_wr(1'b0, 5'd0, 2'd0);
      set_rd(0, 5'd31, 2'd0);
      set_rd(1, 5'd31, 2'd0);
      settle();
      total_cnt++; if (stall !== 1'b0) $display("FAIL jal_stall: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== sr(STG_E)) $display("FAIL jal_fwd0: got %h want %h", fwd0, sr(STG_E)); else pass_cnt++;
      total_cnt++; if (fwd1 !== sr(STG_E)) $display("FAIL jal_fwd1: got %h want %h", fwd1, sr(STG_E)); else pass_cnt++;
   endtask

   // $8 pending in E (Tnew 1) and W (Tnew 0): W must not be used
   task automatic test_youngest();
      do_reset();
      set_wr(1'b1, 5'd8, 2'd0);
      step();
      set_wr(1'b0, 5'd0, 2'd0);
      step();
      set_wr(1'b1, 5'd8, 2'd1);
      step();
      set_wr(1'b0, 5'd0, 2'd0);
      set_rd(0, 5'd8, 2'd0);
      set_rd(1, 5'd8, 2'd1);
      settle();
      total_cnt++; if (stall !== 1'b1) $display("FAIL youngest_stall: got %b want 1", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== RF0) $display("FAIL youngest_fwd0: got %h want %h", fwd0, RF0); else pass_cnt++;
      total_cnt++; if (fwd1 !== RF1) $display("FAIL youngest_fwd1: got %h want %h", fwd1, RF1); else pass_cnt++;
      step();
      settle();
      total_cnt++; if (stall !== 1'b0) $display("FAIL youngest_release: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== sr(STG_M)) $display("FAIL youngest_fwd0_m: got %h want %h", fwd0, sr(STG_M)); else pass_cnt++;
      total_cnt++; if (fwd1 !== sr(STG_M)) $display("FAIL youngest_fwd1_m: got %h want %h", fwd1, sr(STG_M)); else pass_cnt++;
   endtask

   // Writes to $0 never create a dependency
   task automatic test_zero_reg();
      do_reset();
      set_wr(1'b1, 5'd0, 2'd2);
      step();
      set_wr(1'b0, 5'd0, 2'd0);
      set_rd(0, 5'd0, 2'd0);
      set_rd(1, 5'd0, 2'd0);
      settle();
      total_cnt++; if (stall !== 1'b0) $display("FAIL zero_reg_stall: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== RF0) $display("FAIL zero_reg_fwd0: got %h want %h", fwd0, RF0); else pass_cnt++;
      total_cnt++; if (fwd1 !== RF1) $display("FAIL zero_reg_fwd1: got %h want %h", fwd1, RF1); else pass_cnt++;
   endtask

   // Back-to-back ready producers: port 0 reads last write (E), port 1 the one before (M)
   task automatic test_back_to_back();
      logic [DW-1:0] exp0;
      logic [DW-1:0] exp1;
      do_reset();
      set_wr(1'b1, 5'd10, 2'd0);
      step();
      for (int i = 1; i <= 4; i++) begin
         set_wr(1'b1, 5'(10 + i), 2'd0);
         set_rd(0, 5'(9 + i), 2'd0);
         set_rd(1, 5'(8 + i), 2'd0);
         exp_q.push_back(sr(STG_E));
         exp_q.push_back((i >= 2) ? sr(STG_M) : RF1);
         settle();
         exp0 = exp_q.pop_front();
         exp1 = exp_q.pop_front();
         total_cnt++; if (stall !== 1'b0) $display("FAIL b2b_stall[%0d]: got %b want 0", i, stall); else pass_cnt++;
         total_cnt++; if (fwd0 !== exp0) $display("FAIL b2b_fwd0[%0d]: got %h want %h", i, fwd0, exp0); else pass_cnt++;
         total_cnt++; if (fwd1 !== exp1) $display("FAIL b2b_fwd1[%0d]: got %h want %h", i, fwd1, exp1); else pass_cnt++;
         step();
      end
   endtask

   // Reset with pending writes empties the scoreboard; D write during reset is dropped
   task automatic test_reset_mid();
      do_reset();
      set_wr(1'b1, 5'd12, 2'd2);
      step();
      set_wr(1'b0, 5'd0, 2'd0);
      set_rd(0, 5'd12, 2'd0);
      settle();
      total_cnt++; if (stall !== 1'b1) $display("FAIL reset_mid_pre: got %b want 1", stall); else pass_cnt++;
      reset = 1'b1;
      set_wr(1'b1, 5'd13, 2'd2);
      step();
      reset = 1'b0;
      set_wr(1'b0, 5'd0, 2'd0);
      set_rd(1, 5'd13, 2'd0);
      settle();
      total_cnt++; if (stall !== 1'b0) $display("FAIL reset_mid_stall: got %b want 0", stall); else pass_cnt++;
      total_cnt++; if (fwd0 !== RF0) $display("FAIL reset_mid_fwd0: got %h want %h", fwd0, RF0); else pass_cnt++;
      total_cnt++; if (fwd1 !== RF1) $display("FAIL reset_mid_fwd1: got %h want %h", fwd1, RF1); else pass_cnt++;
   endtask

`ifdef MDU_EN
   task automatic test_mdu();
      int n;
      do_reset();
      md_start = 1'b1; md_div = 1'b1; md_use_d = 1'b1;
      settle();
      total_cnt++; if (stall !== 1'b0) $display("FAIL mdu_div_issue: got %b want 0", stall); else pass_cnt++;
      step();
      md_start = 1'b0;
      settle();
      total_cnt++; if (md_busy !== 1'b1) $display("FAIL mdu_busy: got %b want 1", md_busy); else pass_cnt++;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (!stall) break;
         n++;
         step();
      end
      total_cnt++; if (n != DIV_LAT) $display("FAIL mdu_div_stall_cycles: got %0d want %0d", n, DIV_LAT); else pass_cnt++;
      total_cnt++; if (md_busy !== 1'b0) $display("FAIL mdu_div_done: got %b want 0", md_busy); else pass_cnt++;
      md_start = 1'b1; md_div = 1'b0; md_use_d = 1'b0;
      step();
      md_start = 1'b0; md_use_d = 1'b1;
      n = 0;
      for (int i = 0; i < 30; i++) begin
         if (!stall) break;
         n++;
         step();
      end
      total_cnt++; if (n != MUL_LAT) $display("FAIL mdu_mul_stall_cycles: got %0d want %0d", n, MUL_LAT); else pass_cnt++;
      md_start = 1'b1; md_div = 1'b1; md_use_d = 1'b0;
      step();
      md_start = 1'b0; md_use_d = 1'b1;
      reset = 1'b1;
      step();
      reset = 1'b0;
      settle();
      total_cnt++; if (md_busy !== 1'b0) $display("FAIL mdu_reset_busy: got %b want 0", md_busy); else pass_cnt++;
      total_cnt++; if (stall !== 1'b0) $display("FAIL mdu_reset_stall: got %b want 0", stall); else pass_cnt++;
   endtask
`else
   // md_* inputs have no effect when the mult/div unit is not built
   task automatic test_mdu();
      do_reset();
      md_start = 1'b1; md_div = 1'b1; md_use_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         total_cnt++; if (md_busy !== 1'b0) $display("FAIL mdu_off_busy[%0d]: got %b want 0", i, md_busy); else pass_cnt++;
         total_cnt++; if (stall !== 1'b0) $display("FAIL mdu_off_stall[%0d]: got %b want 0", i, stall); else pass_cnt++;
         step();
      end
   endtask
`endif

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1;
      idle_inputs();
      rf_rd = {RF1, RF0};
      for (int k = 0; k < NSTAGE; k++) begin
         stage_res[k*DW +: DW] = sr(k);
      end
      test_reset();
      test_alu_branch();
      test_load_use();
      test_jal();
      test_youngest();
      test_zero_reg();
      test_back_to_back();
      test_reset_mid();
      test_mdu();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
